mcht_trx: RTL and testbench
===========================

# mcht_trx

Manchester-encoded serial transceiver, packaged as the TinyTapeout user macro `tt_um_patrick_lin_git_mcht_trx`. It serializes a byte from the dedicated inputs onto a Manchester line. It also receives and decodes Manchester frames from an input pin or from an internal loopback. The received byte appears on the dedicated outputs. Status and line signals use the bidirectional pins.

## Interface
Parameters:
- `HALF_BIT`, default 4: clock cycles per Manchester half-bit. Must be an even number, 4 or more.

Ports:
- `clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `rst_n` input, 1 bit: reset. One clock; reset is synchronous and active-high. Despite the codebase name, `rst_n` = 1 resets the block on the next rising clock edge.
- `ena` input, 1 bit: design selected. When 0, new `tx_start` requests are ignored; all other logic keeps running.
- `ui_in` input, 8 bits: TX data byte, sampled when a transmit is accepted.
- `uo_out` output, 8 bits: last correctly received byte.
- `uio_in` input, 8 bits:
  - [0] `tx_start`, level-sampled.
  - [1] `rx_line`, the external Manchester input.
  - [2] `loopback`: 1 selects the internal TX line as the RX source.
  - [7:3] unused.
- `uio_out` output, 8 bits:
  - [3] `tx_line`.
  - [4] `tx_busy`.
  - [5] `rx_valid`.
  - [6] `rx_error`.
  - [2:0] and [7] always 0.
- `uio_oe` output, 8 bits: constant 8'b1111_1000.

## Operation
- Encoding follows IEEE 802.3 Manchester:
  - Bit 1 = low for HALF_BIT cycles, then high for HALF_BIT cycles.
  - Bit 0 = high, then low.
  - Idle line = low.
- Frame: one start bit (value 1), then 8 data bits MSB first, then return to idle low.
- TX states are IDLE and SEND.
  - IDLE→SEND when `tx_start`=1, `ena`=1 and `tx_busy`=0. `ui_in` is latched into the shift register at that edge.
  - SEND→IDLE after 9 bits × 2 × HALF_BIT cycles.
  - `tx_start` while busy is ignored.
  - If `tx_start` is still held when the frame ends, a new frame starts immediately.
- RX source is `tx_line` when `loopback`=1, otherwise `rx_line`. The selected source passes through a 2-flop synchronizer.
- RX states are IDLE, DATA and DONE.
  - IDLE: wait for a rising edge on the synchronized line (previous sample 0, current sample 1). This edge is the start bit's mid-bit transition, cycle t0.
  - DATA: data bit k (k = 0..7) has two sample points. The first-half sample is taken at t0 + HALF_BIT + 2·HALF_BIT·k + HALF_BIT/2. The second-half sample is taken one HALF_BIT later.
  - Bit value = second-half sample. If the two samples are equal, the bit is a code violation: pulse `rx_error` for 1 cycle, discard the byte, return to IDLE.
  - DONE: after the 8th bit, the byte is written to `uo_out` and `rx_valid` pulses for 1 cycle. Return to IDLE.
  - If the line is high in IDLE, wait for it to go low, then watch for the next rising edge.
- `uo_out` holds its value until the next valid byte. Errors never modify it.
- TX and RX are independent and may run simultaneously.

## Timing
- Reset values:
  - `uo_out`=0, `tx_line`=0, `tx_busy`=0, `rx_valid`=0, `rx_error`=0.
  - Both FSMs in IDLE; synchronizer flops cleared to 0.
- Reset asserted mid-frame aborts TX and RX at the next edge. `tx_line` goes low and no `rx_valid` is issued.
- TX latency:
  - `tx_start` sampled at edge E. `tx_busy`=1 and the first start-bit half (low) are driven from E.
  - The start bit's rising mid-transition occurs at E + HALF_BIT.
  - `tx_busy` stays high for exactly 18·HALF_BIT cycles (72 at default).
- RX latency:
  - The synchronizer adds 2 cycles after a line change.
  - `uo_out` and `rx_valid` update on the cycle after the final sample, i.e. at t0 + 16·HALF_BIT + HALF_BIT/2 + 1.
- In loopback with the default parameter, `rx_valid` fires a fixed number of cycles after acceptance. The bench must compute that count from the formulas above and check it exactly.

## Test plan
- Reset: hold `rst_n`=1 for 2 cycles, then release → `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xF8.
- TX waveform: `ui_in`=0xA5, pulse `tx_start` with `ena`=1.
  - `tx_line` shows the start bit, then bits 1,0,1,0,0,1,0,1, each 8 cycles long with the correct half-bit polarity.
  - `tx_busy` is high for 72 cycles, then low.
- Loopback: `loopback`=1, send 0x3C → exactly one `rx_valid` pulse, `uo_out`=0x3C, `rx_error` never asserted.
- Busy/ena gating:
  - A second `tx_start` mid-frame with `ui_in`=0xFF does not alter the frame.
  - `tx_start` with `ena`=0 → `tx_busy` stays 0.
- Code violation: external `rx_line` is driven with a rising edge, then held high for 3·HALF_BIT → one `rx_error` pulse, no `rx_valid`, `uo_out` unchanged.
- Reset mid-frame: assert reset 20 cycles into a loopback frame → `tx_line`=0, no `rx_valid`. A following frame of 0x81 is received correctly.

Source files
------------

// File: rtl/mcht_trx.sv
// Manchester-encoded serial transceiver (TinyTapeout user macro core).
// TX serializes a start bit plus a byte MSB first; RX decodes from rx_line or the TX loopback.
module mcht_trx #(
  parameter int unsigned HALF_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = $clog2(HALF_BIT);
  localparam int unsigned PhW  = $clog2(2 * HALF_BIT);

  localparam logic [CntW-1:0] CntLast  = CntW'(HALF_BIT - 1);
  localparam logic [PhW-1:0]  PhFirst  = PhW'(HALF_BIT - 1);
  localparam logic [PhW-1:0]  PhSecond = PhW'(2 * HALF_BIT - 1);
  // Phase preset so the first-half sample of data bit 0 lands 1.5 half-bits after t0.
  localparam logic [PhW-1:0]  PhInit   = PhW'(3 * HALF_BIT / 2);

  typedef enum logic {StTxIdle, StTxSend} tx_state_e;
  typedef enum logic [1:0] {StRxIdle, StRxData, StRxDone} rx_state_e;

  // The codebase calls it rst_n, but it is an active-high synchronous reset.
  logic rst;
  assign rst = rst_n;

  logic tx_start, rx_line, loopback;
  assign tx_start = uio_in[0];
  assign rx_line  = uio_in[1];
  assign loopback = uio_in[2];

  logic unused_uio;
  assign unused_uio = ^uio_in[7:3];

  // ---------------- TX ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [4:0]      tx_half_q, tx_half_d;
  logic [8:0]      tx_sh_q, tx_sh_d;
  logic            tx_busy, tx_line;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_half_d  = tx_half_q;
    tx_sh_d    = tx_sh_q;
    unique case (tx_state_q)
      StTxIdle: begin
        if (tx_start && ena) begin
          tx_state_d = StTxSend;
          tx_cnt_d   = '0;
          tx_half_d  = '0;
          tx_sh_d    = {1'b1, ui_in};
        end
      end
      StTxSend: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_half_q == 5'd17) begin
            tx_state_d = StTxIdle;
          end else begin
            tx_half_d = tx_half_q + 5'd1;
            if (tx_half_q[0]) tx_sh_d = {tx_sh_q[7:0], 1'b0};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  assign tx_busy = (tx_state_q == StTxSend);
  // First half carries the inverted bit, second half the bit itself.
  assign tx_line = tx_busy & ~(tx_sh_q[8] ^ tx_half_q[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StTxIdle;
      tx_cnt_q   <= '0;
      tx_half_q  <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_half_q  <= tx_half_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  // ---------------- RX ----------------
  logic           sync1_q, sync2_q, prev_q;
  rx_state_e      rx_state_q, rx_state_d;
  logic [PhW-1:0] rx_ph_q, rx_ph_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic           rx_have_first_q, rx_have_first_d;
  logic           rx_first_q, rx_first_d;
  logic [7:0]     rx_sh_q, rx_sh_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_error_q, rx_error_d;
  logic           rx_valid;

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_ph_d         = rx_ph_q;
    rx_bit_d        = rx_bit_q;
    rx_have_first_d = rx_have_first_q;
    rx_first_d      = rx_first_q;
    rx_sh_d         = rx_sh_q;
    rx_data_d       = rx_data_q;
    rx_error_d      = 1'b0;
    unique case (rx_state_q)
      StRxIdle: begin
        if (sync2_q && !prev_q) begin
          rx_state_d      = StRxData;
          rx_ph_d         = PhInit;
          rx_bit_d        = '0;
          rx_have_first_d = 1'b0;
        end
      end
      StRxData: begin
        rx_ph_d = (rx_ph_q == PhSecond) ? '0 : rx_ph_q + PhW'(1);
        if (rx_ph_q == PhFirst) begin
          rx_first_d      = sync2_q;
          rx_have_first_d = 1'b1;
        end
        // The phase wraps once before bit 0's first sample; have_first masks it.
        if (rx_ph_q == PhSecond && rx_have_first_q) begin
          if (rx_first_q == sync2_q) begin
            rx_error_d = 1'b1;
            rx_state_d = StRxIdle;
          end else begin
            rx_sh_d = {rx_sh_q[6:0], sync2_q};
            if (rx_bit_q == 3'd7) begin
              rx_data_d  = {rx_sh_q[6:0], sync2_q};
              rx_state_d = StRxDone;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
        end
      end
      StRxDone: rx_state_d = StRxIdle;
      default:  rx_state_d = StRxIdle;
    endcase
  end

  assign rx_valid = (rx_state_q == StRxDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      prev_q          <= 1'b0;
      rx_state_q      <= StRxIdle;
      rx_ph_q         <= '0;
      rx_bit_q        <= '0;
      rx_have_first_q <= 1'b0;
      rx_first_q      <= 1'b0;
      rx_sh_q         <= '0;
      rx_data_q       <= '0;
      rx_error_q      <= 1'b0;
    end else begin
      sync1_q         <= loopback ? tx_line : rx_line;
      sync2_q         <= sync1_q;
      prev_q          <= sync2_q;
      rx_state_q      <= rx_state_d;
      rx_ph_q         <= rx_ph_d;
      rx_bit_q        <= rx_bit_d;
      rx_have_first_q <= rx_have_first_d;
      rx_first_q      <= rx_first_d;
      rx_sh_q         <= rx_sh_d;
      rx_data_q       <= rx_data_d;
      rx_error_q      <= rx_error_d;
    end
  end

  assign uo_out  = rx_data_q;
  assign uio_out = {1'b0, rx_error_q, rx_valid, tx_busy, tx_line, 3'b000};
  assign uio_oe  = 8'b1111_1000;

endmodule

// File: tb/tb_mcht_trx.sv
// Self-checking bench for mcht_trx: directed steps plus random loopback bytes against a
// frame-level Manchester model.
module tb_mcht_trx;

  localparam int unsigned HB = 4;
  // Line change at E+HB, 2 sync cycles, then t0 + 16*HB + HB/2 + 1.
  localparam int RxLat = HB + 2 + 16 * HB + HB / 2 + 1;

  logic       clk = 1'b0;
  logic       rst_n, ena, tx_start, rx_line, loopback;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       tx_line, tx_busy, rx_valid, rx_error;

  int vectors = 0, miscompares = 0, nvalid = 0, nerr = 0;
  logic [7:0] exp_uo;

  assign uio_in   = {5'b0, loopback, rx_line, tx_start};
  assign tx_line  = uio_out[3];
  assign tx_busy  = uio_out[4];
  assign rx_valid = uio_out[5];
  assign rx_error = uio_out[6];

  mcht_trx #(.HALF_BIT(HB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid) nvalid++;
    if (rx_error) nerr++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level n cycles after acceptance for a frame carrying byte b.
  function automatic logic tx_level(input logic [7:0] b, input int n);
    logic [8:0] frame;
    int         h;
    logic       bitv;
    frame = {1'b1, b};
    h     = n / HB;
    bitv  = frame[8 - h / 2];
    return (h % 2 == 1) ? bitv : ~bitv;
  endfunction

  task automatic send_loop(input logic [7:0] b);
    int lat, v0, e0;
    loopback = 1'b1;
    ui_in    = b;
    tx_start = 1'b1;
    v0       = nvalid;
    e0       = nerr;
    tick();
    tx_start = 1'b0;
    lat      = -1;
    for (int n = 1; n <= 120; n++) begin
      tick();
      if (rx_valid && lat < 0) lat = n;
    end
    chk("loop_latency", 16'(lat), 16'(RxLat));
    chk("loop_data", {8'h0, uo_out}, {8'h0, b});
    chk("loop_valid_count", 16'(nvalid - v0), 16'd1);
    chk("loop_error_count", 16'(nerr - e0), 16'd0);
    exp_uo = b;
  endtask

  initial begin
    int v0, e0;
    rst_n    = 1'b1;
    ena      = 1'b1;
    ui_in    = 8'h00;
    tx_start = 1'b0;
    rx_line  = 1'b0;
    loopback = 1'b0;
    exp_uo   = 8'h00;

    // Reset
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("reset_uo_out", {8'h0, uo_out}, 16'h00);
    chk("reset_uio_out", {8'h0, uio_out}, 16'h00);
    chk("reset_uio_oe", {8'h0, uio_oe}, 16'hF8);

    // TX waveform for 0xA5, with an ignored tx_start (ui_in=0xFF) mid-frame
    ui_in    = 8'hA5;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int n = 0; n < 18 * HB; n++) begin
      chk("tx_wave", {14'h0, tx_busy, tx_line}, {14'h0, 1'b1, tx_level(8'hA5, n)});
      if (n == 20) begin
        ui_in    = 8'hFF;
        tx_start = 1'b1;
      end
      if (n == 22) tx_start = 1'b0;
      tick();
    end
    chk("tx_end_idle", {14'h0, tx_busy, tx_line}, 16'h0);

    // ena=0 gating
    ena      = 1'b0;
    tx_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ena_gate_busy", {15'h0, tx_busy}, 16'h0);
    end
    tx_start = 1'b0;
    ena      = 1'b1;
    tick();

    // Loopback: fixed byte then random bytes
    send_loop(8'h3C);
    for (int i = 0; i < 5; i++) send_loop(8'($urandom_range(0, 255)));

    // Code violation on external line
    loopback = 1'b0;
    v0       = nvalid;
    e0       = nerr;
    rx_line  = 1'b1;
    repeat (3 * HB) tick();
    rx_line = 1'b0;
    repeat (40) tick();
    chk("viol_error_count", 16'(nerr - e0), 16'd1);
    chk("viol_valid_count", 16'(nvalid - v0), 16'd0);
    chk("viol_uo_kept", {8'h0, uo_out}, {8'h0, exp_uo});

    // Reset 20 cycles into a loopback frame
    loopback = 1'b1;
    ui_in    = 8'($urandom_range(0, 255));
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("rst_mid_tx", {14'h0, tx_busy, tx_line}, 16'h0);
    chk("rst_mid_uo", {8'h0, uo_out}, 16'h00);
    v0 = nvalid;
    repeat (100) tick();
    chk("rst_mid_no_valid", 16'(nvalid - v0), 16'd0);
    send_loop(8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
